// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the 5-stage RV32I pipeline
//
// Central hazard controller. It resolves load-use hazards, EX-stage redirects,
// fetch latency and data-memory wait states. It also drops stale wrong-path
// fetch responses and counts stall cycles.
//
// Ports:
//   ACLK, ARESETn            clock, asynchronous active-low reset
//   id_rs1_i/id_rs2_i        source register indices of the instruction in ID
//   id_use_rs1_i/_rs2_i      ID instruction actually reads rs1/rs2
//   ex_rd_i, ex_mem_read_i   destination and load flag of the instruction in EX
//   ex_redirect_i            EX resolved a taken branch/jump this cycle
//   imem_valid_i/_ready_o    fetch response handshake
//   dmem_req_i/_done_i       MEM-stage access pending / completing
//   *_stall_o, *_flush_o     pipeline register enables (flush wins in buffers)
//   cnt_clr_i                synchronous clear of the stall counter
//   stall_cycles_o           saturating count of cycles with pc_stall_o=1
module pipe_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_redirect_i,
  input  logic             imem_valid_i,
  output logic             imem_ready_o,
  input  logic             dmem_req_i,
  input  logic             dmem_done_i,
  output logic             pc_stall_o,
  output logic             if2id_stall_o,
  output logic             if2id_flush_o,
  output logic             id2ex_stall_o,
  output logic             id2ex_flush_o,
  output logic             ex2mem_stall_o,
  output logic             mem2wb_flush_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] stall_cycles_o
);

  typedef enum logic {RUN = 1'b0, DISCARD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic dwait;
  logic lu;

  assign dwait = dmem_req_i & ~dmem_done_i;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu = ex_mem_read_i & (ex_rd_i != '0) &
              ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
               (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

  // State register and stall counter
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!dwait) begin
      case (state_q)
        // Only the stale wrong-path word ends DISCARD; a further redirect
        // leaves the one outstanding fetch still pending.
        DISCARD: if (imem_valid_i) state_d = RUN;
        // A redirect with no response in hand leaves a wrong-path fetch in flight.
        RUN:     if (ex_redirect_i && !imem_valid_i) state_d = DISCARD;
        default: state_d = RUN;
      endcase
    end
  end

  // Output logic
  always_comb begin
    pc_stall_o     = 1'b0;
    if2id_stall_o  = 1'b0;
    if2id_flush_o  = 1'b0;
    id2ex_stall_o  = 1'b0;
    id2ex_flush_o  = 1'b0;
    ex2mem_stall_o = 1'b0;
    mem2wb_flush_o = 1'b0;
    imem_ready_o   = 1'b1;
    if (dwait) begin
      // Full freeze. EX is held, so a pending redirect is replayed once MEM completes.
      pc_stall_o     = 1'b1;
      if2id_stall_o  = 1'b1;
      id2ex_stall_o  = 1'b1;
      ex2mem_stall_o = 1'b1;
      mem2wb_flush_o = 1'b1;
      imem_ready_o   = 1'b0;
    end else if (state_q == DISCARD) begin
      pc_stall_o    = 1'b1;
      if2id_flush_o = 1'b1;
      id2ex_flush_o = ex_redirect_i;
    end else if (ex_redirect_i) begin
      if2id_flush_o = 1'b1;
      id2ex_flush_o = 1'b1;
    end else if (lu) begin
      // Hold the fetch response so the held ID instruction is not overwritten.
      pc_stall_o    = 1'b1;
      if2id_stall_o = 1'b1;
      id2ex_flush_o = 1'b1;
      imem_ready_o  = 1'b0;
    end else if (!imem_valid_i) begin
      pc_stall_o    = 1'b1;
      if2id_flush_o = 1'b1;
    end
  end

  // Stall counter: clear wins over increment, saturates at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr_i) begin
      stall_cnt_d = '0;
    end else if (pc_stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard testbench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [4:0]  id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
  logic        id_use_rs1_i = 1'b0, id_use_rs2_i = 1'b0;
  logic        ex_mem_read_i = 1'b0, ex_redirect_i = 1'b0;
  logic        imem_valid_i = 1'b1;
  logic        dmem_req_i = 1'b0, dmem_done_i = 1'b0, cnt_clr_i = 1'b0;

  logic        imem_ready_o, pc_stall_o, if2id_stall_o, if2id_flush_o;
  logic        id2ex_stall_o, id2ex_flush_o, ex2mem_stall_o, mem2wb_flush_o;
  logic [31:0] stall_cycles_o;

  logic        s_imem_ready, s_pc_stall, s_if2id_stall, s_if2id_flush;
  logic        s_id2ex_stall, s_id2ex_flush, s_ex2mem_stall, s_mem2wb_flush;
  logic [1:0]  s_stall_cycles;

  always #5 ACLK = ~ACLK;

  pipe_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_rd_i(ex_rd_i), .ex_mem_read_i(ex_mem_read_i), .ex_redirect_i(ex_redirect_i),
    .imem_valid_i(imem_valid_i), .imem_ready_o(imem_ready_o),
    .dmem_req_i(dmem_req_i), .dmem_done_i(dmem_done_i),
    .pc_stall_o(pc_stall_o), .if2id_stall_o(if2id_stall_o), .if2id_flush_o(if2id_flush_o),
    .id2ex_stall_o(id2ex_stall_o), .id2ex_flush_o(id2ex_flush_o),
    .ex2mem_stall_o(ex2mem_stall_o), .mem2wb_flush_o(mem2wb_flush_o),
    .cnt_clr_i(cnt_clr_i), .stall_cycles_o(stall_cycles_o)
  );

  // Narrow-counter instance driven identically, so saturation is reachable.
  pipe_hazard_ctrl #(.REG_W(5), .CNT_W(2)) dut_sat (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_rd_i(ex_rd_i), .ex_mem_read_i(ex_mem_read_i), .ex_redirect_i(ex_redirect_i),
    .imem_valid_i(imem_valid_i), .imem_ready_o(s_imem_ready),
    .dmem_req_i(dmem_req_i), .dmem_done_i(dmem_done_i),
    .pc_stall_o(s_pc_stall), .if2id_stall_o(s_if2id_stall), .if2id_flush_o(s_if2id_flush),
    .id2ex_stall_o(s_id2ex_stall), .id2ex_flush_o(s_id2ex_flush),
    .ex2mem_stall_o(s_ex2mem_stall), .mem2wb_flush_o(s_mem2wb_flush),
    .cnt_clr_i(cnt_clr_i), .stall_cycles_o(s_stall_cycles)
  );

  typedef struct packed {
    logic [31:0] id;
    logic [7:0]  outs;
    logic [31:0] cnt;
    logic [1:0]  scnt;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_cnt = '0;
  logic [1:0]  m_scnt = '0;
  int          vec_id = 0;

  // Bit order: pc_stall, if2id_stall, if2id_flush, id2ex_stall,
  //            id2ex_flush, ex2mem_stall, mem2wb_flush, imem_ready
  logic [7:0] act_outs, act_souts;
  assign act_outs  = {pc_stall_o, if2id_stall_o, if2id_flush_o, id2ex_stall_o,
                      id2ex_flush_o, ex2mem_stall_o, mem2wb_flush_o, imem_ready_o};
  assign act_souts = {s_pc_stall, s_if2id_stall, s_if2id_flush, s_id2ex_stall,
                      s_id2ex_flush, s_ex2mem_stall, s_mem2wb_flush, s_imem_ready};

  // Monitor: outputs are combinational and valid every cycle once a vector is applied.
  always @(negedge ACLK) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (act_outs !== e.outs) begin
        errors++;
        $display("FAIL outs vec=%0d got=%b exp=%b", e.id, act_outs, e.outs);
      end
      checks++;
      if (act_souts !== e.outs) begin
        errors++;
        $display("FAIL outs_narrow vec=%0d got=%b exp=%b", e.id, act_souts, e.outs);
      end
      checks++;
      if (stall_cycles_o !== e.cnt) begin
        errors++;
        $display("FAIL stall_cycles vec=%0d got=%h exp=%h", e.id, stall_cycles_o, e.cnt);
      end
      checks++;
      if (s_stall_cycles !== e.scnt) begin
        errors++;
        $display("FAIL stall_cycles_sat vec=%0d got=%0d exp=%0d", e.id, s_stall_cycles, e.scnt);
      end
    end
  end

  task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic ld,
                       input logic redir, input logic iv, input logic dq, input logic dd,
                       input logic clr, input logic rn, input logic [7:0] exp_outs);
    exp_t e;
    @(posedge ACLK);
    #1;
    id_rs1_i = rs1; id_use_rs1_i = u1; id_rs2_i = rs2; id_use_rs2_i = u2;
    ex_rd_i = rd; ex_mem_read_i = ld; ex_redirect_i = redir; imem_valid_i = iv;
    dmem_req_i = dq; dmem_done_i = dd; cnt_clr_i = clr; ARESETn = rn;
    e.id   = vec_id;
    e.outs = exp_outs;
    e.cnt  = rn ? m_cnt : 32'd0;
    e.scnt = rn ? m_scnt : 2'd0;
    sb.push_back(e);
    vec_id++;
    if (!rn || clr) begin
      m_cnt  = '0;
      m_scnt = '0;
    end else if (exp_outs[7]) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (m_scnt != 2'd3) m_scnt = m_scnt + 2'd1;
    end
  endtask

  initial begin
    //     rs1 u1 rs2 u2 rd ld rdr iv dq dd clr rn  expected
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'b00000001); // in reset
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 8'b00000001); // idle
    drive(5, 1, 1, 1, 5, 1, 0, 1, 0, 0, 0, 1, 8'b11001000); // load-use rs1
    drive(6, 1, 5, 1, 5, 0, 0, 1, 0, 0, 0, 1, 8'b00000001); // one bubble only
    drive(0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 8'b00000001); // lw x0: no hazard
    drive(3, 1, 7, 1, 7, 1, 0, 1, 0, 0, 0, 1, 8'b11001000); // load-use rs2
    drive(3, 1, 7, 0, 7, 1, 0, 1, 0, 0, 0, 1, 8'b00000001); // rs2 not read
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'b10100001); // fetch miss
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 8'b00101001); // redirect -> DISCARD
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'b10100001); // discard wait
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'b10100001);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 8'b10101001); // redirect in DISCARD
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 8'b10100001); // stale word dropped
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 8'b00000001); // back in RUN
    for (int i = 0; i < 4; i++)
      drive(5, 1, 0, 0, 5, 1, 1, 0, 1, 0, 0, 1, 8'b11010110); // dwait freeze
    drive(5, 1, 0, 0, 5, 1, 1, 1, 1, 1, 0, 1, 8'b00101001); // done: redirect acts
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 8'b00000001); // stayed RUN
    drive(9, 1, 0, 0, 9, 1, 1, 1, 0, 0, 0, 1, 8'b00101001); // redirect beats lu
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 8'b00101001); // -> DISCARD
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 8'b11010110); // dwait in DISCARD
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 8'b11010110);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 8'b10100001); // still DISCARD, drop
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 8'b00000001); // RUN
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 8'b10100001); // clear beats increment
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 8'b00000001); // counter reads 0
    for (int i = 0; i < 5; i++)
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'b10100001); // narrow counter saturates
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 8'b00000001);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 8'b00101001); // -> DISCARD
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 8'b00000001); // reset in DISCARD
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 8'b00000001); // RUN after reset
    @(posedge ACLK);
    @(negedge ACLK);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
